// File: rtl/stopwatch_pkg.sv
// Shared types, digit geometry and BCD increment helper for the stopwatch toggle generator.
// Define STOPWATCH_SEXAGESIMAL_EN for MM:SS digit maxima (9,5,9,5); default is decimal 0000..9999.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE
    } state_t;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_W      = 4;
    localparam int VEC_W      = NUM_DIGITS * BCD_W;

    // Digit maxima packed with digit 0 in the least significant nibble.
    localparam logic [VEC_W-1:0] DEC_MAX = {4'd9, 4'd9, 4'd9, 4'd9};
    localparam logic [VEC_W-1:0] SEX_MAX = {4'd5, 4'd9, 4'd5, 4'd9};

`ifdef STOPWATCH_SEXAGESIMAL_EN
    localparam logic [VEC_W-1:0] DIGIT_MAX = SEX_MAX;
`else
    localparam logic [VEC_W-1:0] DIGIT_MAX = DEC_MAX;
`endif

    // Ripple-carry BCD increment; an out-of-range digit always recovers to 0.
    function automatic logic [VEC_W-1:0] bcd_next(input logic [VEC_W-1:0] q);
        logic             carry;
        logic [BCD_W-1:0] d;
        logic [BCD_W-1:0] m;
        bcd_next = '0;
        carry    = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d = q[i*BCD_W +: BCD_W];
            m = DIGIT_MAX[i*BCD_W +: BCD_W];
            if (d > m)
                bcd_next[i*BCD_W +: BCD_W] = '0;
            else if (carry)
                bcd_next[i*BCD_W +: BCD_W] = (d == m) ? '0 : d + 4'd1;
            else
                bcd_next[i*BCD_W +: BCD_W] = d;
            carry = carry & (d == m);
        end
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioning: 2-flop synchronizer, stable-level debouncer, rising-edge press pulse.
module btn_debounce #(
    parameter int DEBOUNCE = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          level;
    logic          level_d;

    // NOTE: all state here uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= '0;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
        end else begin
            sync    <= {sync[0], btn};
            level_d <= level;
            // cnt tracks consecutive samples that disagree with the accepted level.
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE - 1)) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign press = level & ~level_d;

endmodule

// File: rtl/stopwatch_tgen.sv
// Stopwatch toggle generator: button FSM, prescaler and BCD toggle vectors for external T registers.
// Digit maxima follow STOPWATCH_SEXAGESIMAL_EN (see stopwatch_pkg).
module stopwatch_tgen
    import stopwatch_pkg::*;
#(
    parameter int PRESCALE = 100000,
    parameter int DEBOUNCE = 50000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTN_START,
    input  logic       BTN_CLEAR,
    input  logic [3:0] Q0,
    input  logic [3:0] Q1,
    input  logic [3:0] Q2,
    input  logic [3:0] Q3,
    output logic [3:0] T0,
    output logic [3:0] T1,
    output logic [3:0] T2,
    output logic [3:0] T3,
    output logic       RUNNING,
    output logic       TICK
);

    localparam int PW = $clog2(PRESCALE);

    state_t           state;
    state_t           state_nxt;
    logic             start_press;
    logic             clear_press;
    logic [PW-1:0]    pre_cnt;
    logic             tick_flag;
    logic             clr_flag;
    logic [VEC_W-1:0] q_vec;
    logic [VEC_W-1:0] t_vec;

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_start (
        .clk  (CLK),
        .rst_n(RESET),
        .btn  (BTN_START),
        .press(start_press)
    );

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_clear (
        .clk  (CLK),
        .rst_n(RESET),
        .btn  (BTN_CLEAR),
        .press(clear_press)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: defaulting every always_comb output first keeps the tools from inferring latches.
    always_comb begin
        state_nxt = state;
        if (clear_press) begin
            state_nxt = ST_IDLE;
        end else if (start_press) begin
            case (state)
                ST_IDLE:  state_nxt = ST_RUN;
                ST_RUN:   state_nxt = ST_PAUSE;
                ST_PAUSE: state_nxt = ST_RUN;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        RUNNING = (state == ST_RUN);
    end

    // Prescaler runs in RUN, freezes in PAUSE, and restarts from 0 whenever IDLE.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pre_cnt   <= '0;
            tick_flag <= 1'b0;
            clr_flag  <= 1'b0;
        end else begin
            tick_flag <= 1'b0;
            clr_flag  <= clear_press;
            case (state)
                ST_RUN: begin
                    if (pre_cnt == PW'(PRESCALE - 1)) begin
                        pre_cnt   <= '0;
                        tick_flag <= 1'b1;
                    end else begin
                        pre_cnt <= pre_cnt + PW'(1);
                    end
                end
                ST_PAUSE: pre_cnt <= pre_cnt;
                default:  pre_cnt <= '0;
            endcase
        end
    end

    assign q_vec = {Q3, Q2, Q1, Q0};

    // Clear toggles every set bit back to 0 and outranks a coincident tick.
    always_comb begin
        t_vec = '0;
        TICK  = 1'b0;
        if (clr_flag) begin
            t_vec = q_vec;
        end else if (tick_flag) begin
            t_vec = q_vec ^ bcd_next(q_vec);
            TICK  = 1'b1;
        end
    end

    assign {T3, T2, T1, T0} = t_vec;

endmodule

// File: tb/tb_stopwatch_tgen.sv
// Scoreboard bench for stopwatch_tgen with PRESCALE=4, DEBOUNCE=3; directed timeline, hand-computed events.
module tb_stopwatch_tgen;

    localparam int PRESCALE = 4;
    localparam int DEBOUNCE = 3;

`ifdef STOPWATCH_SEXAGESIMAL_EN
    localparam logic [15:0] WRAP_Q = 16'h5959;
    localparam logic [15:0] WRAP_T = 16'h5959;
`else
    localparam logic [15:0] WRAP_Q = 16'h9999;
    localparam logic [15:0] WRAP_T = 16'h9999;
`endif

    typedef struct {
        int          cyc;
        logic        tick;
        logic [15:0] t;
    } ev_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        BTN_START = 1'b0;
    logic        BTN_CLEAR = 1'b0;
    logic [15:0] q_in = 16'h1239;
    logic [3:0]  T0, T1, T2, T3;
    logic        RUNNING, TICK;
    logic [15:0] t_obs;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];

    stopwatch_tgen #(.PRESCALE(PRESCALE), .DEBOUNCE(DEBOUNCE)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .BTN_START(BTN_START),
        .BTN_CLEAR(BTN_CLEAR),
        .Q0       (q_in[3:0]),
        .Q1       (q_in[7:4]),
        .Q2       (q_in[11:8]),
        .Q3       (q_in[15:12]),
        .T0       (T0),
        .T1       (T1),
        .T2       (T2),
        .T3       (T3),
        .RUNNING  (RUNNING),
        .TICK     (TICK)
    );

    assign t_obs = {T3, T2, T1, T0};

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic expect_ev(input int c, input logic tk, input logic [15:0] t);
        ev_t e;
        e.cyc  = c;
        e.tick = tk;
        e.t    = t;
        exp_q.push_back(e);
    endtask

    task automatic expect_ticks(input int first, input int n, input logic [15:0] t);
        for (int k = 0; k < n; k++) expect_ev(first + PRESCALE * k, 1'b1, t);
    endtask

    // Monitor: any visible TICK or toggle must match the next scheduled event exactly.
    always @(negedge CLK) begin
        ev_t e;
        if (RESET === 1'b1 && (TICK !== 1'b0 || t_obs !== 16'h0000)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: cycle %0d tick=%b t=%h, expected no output", cyc, TICK, t_obs);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.tick !== TICK || e.t !== t_obs) begin
                    errors++;
                    $display("FAIL event: cycle %0d tick=%b t=%h, expected cycle %0d tick=%b t=%h",
                             cyc, TICK, t_obs, e.cyc, e.tick, e.t);
                end
            end
        end
    end

    initial begin
        int c0;
        #12;
        check("reset_running", {15'd0, RUNNING}, 16'h0000);
        check("reset_tick", {15'd0, TICK}, 16'h0000);
        check("reset_t", t_obs, 16'h0000);
        wait_to(3);
        RESET = 1'b1;

        c0 = 10;
        wait_to(c0);
        q_in      = 16'h0000;
        BTN_START = 1'b1;
        expect_ticks(c0 + 10, 3, 16'h0001);
        wait_to(c0 + 6);
        BTN_START = 1'b0;
        check("running_after_start", {15'd0, RUNNING}, 16'h0001);

        wait_to(c0 + 19);
        q_in = 16'h0009;
        expect_ev(c0 + 22, 1'b1, 16'h0019);
        wait_to(c0 + 23);
        q_in = WRAP_Q;
        expect_ev(c0 + 26, 1'b1, WRAP_T);
        wait_to(c0 + 27);
        q_in = 16'h000C;
        expect_ev(c0 + 30, 1'b1, 16'h000C);
        wait_to(c0 + 31);
        q_in = 16'h0A99;
        expect_ev(c0 + 34, 1'b1, 16'h0A99);

        // Two-cycle glitch, then a real press into PAUSE.
        wait_to(c0 + 35);
        q_in      = 16'h0000;
        BTN_START = 1'b1;
        expect_ticks(c0 + 38, 3, 16'h0001);
        wait_to(c0 + 37);
        BTN_START = 1'b0;
        wait_to(c0 + 42);
        check("running_after_glitch", {15'd0, RUNNING}, 16'h0001);
        BTN_START = 1'b1;
        wait_to(c0 + 48);
        BTN_START = 1'b0;
        check("running_in_pause", {15'd0, RUNNING}, 16'h0000);
        wait_to(c0 + 58);
        check("running_still_paused", {15'd0, RUNNING}, 16'h0000);
        BTN_START = 1'b1;
        wait_to(c0 + 64);
        BTN_START = 1'b0;
        check("running_after_resume", {15'd0, RUNNING}, 16'h0001);
        expect_ticks(c0 + 66, 2, 16'h0001);

        // Clear press lands in the same cycle the prescaler wraps.
        wait_to(c0 + 71);
        q_in = 16'h3721;
        expect_ticks(c0 + 74, 2, 16'h0003);
        expect_ev(c0 + 82, 1'b0, 16'h3721);
        wait_to(c0 + 76);
        BTN_CLEAR = 1'b1;
        wait_to(c0 + 82);
        BTN_CLEAR = 1'b0;
        check("running_after_clear", {15'd0, RUNNING}, 16'h0000);

        wait_to(c0 + 88);
        q_in      = 16'h0042;
        BTN_CLEAR = 1'b1;
        expect_ev(c0 + 94, 1'b0, 16'h0042);
        wait_to(c0 + 94);
        BTN_CLEAR = 1'b0;
        wait_to(c0 + 95);
        check("running_idle_clear", {15'd0, RUNNING}, 16'h0000);

        wait_to(c0 + 100);
        BTN_START = 1'b1;
        BTN_CLEAR = 1'b1;
        expect_ev(c0 + 106, 1'b0, 16'h0042);
        wait_to(c0 + 106);
        BTN_START = 1'b0;
        BTN_CLEAR = 1'b0;
        wait_to(c0 + 111);
        check("running_clear_wins", {15'd0, RUNNING}, 16'h0000);

        // Restart, then assert reset asynchronously while a tick is on the outputs.
        wait_to(c0 + 112);
        q_in      = 16'h0000;
        BTN_START = 1'b1;
        expect_ev(c0 + 122, 1'b1, 16'h0001);
        wait_to(c0 + 118);
        BTN_START = 1'b0;
        check("running_restart", {15'd0, RUNNING}, 16'h0001);
        wait_to(c0 + 123);
        q_in = 16'h5555;
        wait_to(c0 + 126);
        #2;
        RESET = 1'b0;
        #1;
        check("async_reset_running", {15'd0, RUNNING}, 16'h0000);
        check("async_reset_tick", {15'd0, TICK}, 16'h0000);
        check("async_reset_t", t_obs, 16'h0000);
        wait_to(c0 + 130);
        check("held_reset_running", {15'd0, RUNNING}, 16'h0000);
        check("held_reset_t", t_obs, 16'h0000);
        RESET = 1'b1;
        wait_to(c0 + 136);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: %0d pending, expected 0 (next at cycle %0d)",
                     exp_q.size(), exp_q[0].cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
